alu_issue_stage: RTL and testbench

//  Operand issue/result stage that wraps the add_sub datapath. Buffers add/sub

---
 rtl/alu_pkg.sv | 29 ++
 rtl/add_sub.sv | 27 ++
 rtl/alu_req_fifo.sv | 50 +++++
 rtl/alu_issue_stage.sv | 76 +++++++
 tb/tb_alu_issue_stage.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and flag helper for the add/sub issue path.
package alu_pkg;

  localparam int unsigned ALU_W     = 32;
  localparam int unsigned ALU_DEPTH = 4;
  localparam int unsigned CNT_W     = $clog2(ALU_DEPTH) + 1;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             sub;
  } alu_req_t;

  // Returns {carry, ovf}; carry is a borrow (a < b) for subtraction.
  function automatic logic [1:0] addsub_flags(input logic [ALU_W-1:0] a,
                                              input logic [ALU_W-1:0] b,
                                              input logic             sub);
    logic [ALU_W:0]   sum;
    logic [ALU_W-1:0] bp;
    logic             carry;
    logic             ovf;
    bp    = sub ? (~b + ALU_W'(1)) : b;
    sum   = {1'b0, a} + {1'b0, bp};
    carry = sub ? (a < b) : sum[ALU_W];
    ovf   = (a[ALU_W-1] == bp[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
    return {carry, ovf};
  endfunction

endpackage

// File: rtl/add_sub.sv
// Combinational WIDTH-bit adder/subtractor with carry/borrow and signed overflow.
module add_sub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] b_inv;
  logic [WIDTH-1:0] b_prime;

  // Subtraction is a + ~b + 1; carry-out of that is !borrow.
  always_comb begin
    b_inv   = sub ? ~b : b;
    b_prime = sub ? (~b + WIDTH'(1)) : b;
    sum     = {1'b0, a} + {1'b0, b_inv} + (WIDTH+1)'(sub);
    res     = sum[WIDTH-1:0];
    carry   = sub ? ~sum[WIDTH] : sum[WIDTH];
    ovf     = (a[WIDTH-1] == b_prime[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_req_fifo.sv
// Request FIFO for add/sub operands; full/empty tracked by occupancy count.
module alu_req_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [2*WIDTH:0]         wdata,
  input  logic                     pop,
  output logic [2*WIDTH:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_B = $clog2(DEPTH) + 1;

  logic [2*WIDTH:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_B'(1);
        2'b01:   count <= count - CNT_B'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/alu_issue_stage.sv
// Buffers add/sub requests and returns registered results on a valid/ready port.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W,
  parameter int unsigned DEPTH = ALU_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_a,
  input  logic [WIDTH-1:0]       req_b,
  input  logic                   req_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_res,
  output logic                   rsp_carry,
  output logic                   rsp_ovf,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CNT_B = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic [2*WIDTH:0] head;
  logic [WIDTH-1:0] as_res;
  logic             as_carry;
  logic             as_ovf;

  assign req_ready = !flush && (count != CNT_B'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (count != '0) && (!rsp_valid || rsp_ready) && !flush;

  alu_req_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata ({req_a, req_b, req_sub}),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  add_sub #(.WIDTH(WIDTH)) u_add_sub (
    .a     (head[2*WIDTH:WIDTH+1]),
    .b     (head[WIDTH:1]),
    .sub   (head[0]),
    .res   (as_res),
    .carry (as_carry),
    .ovf   (as_ovf)
  );

  // Result payload only changes on pop, so it holds under backpressure and after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_res   <= '0;
      rsp_carry <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (pop) begin
      rsp_valid <= 1'b1;
      rsp_res   <= as_res;
      rsp_carry <= as_carry;
      rsp_ovf   <= as_ovf;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed check of alu_issue_stage against a queue-based model.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_sub;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_res;
  logic         rsp_carry;
  logic         rsp_ovf;
  logic [2:0]   count;

  int n_checks = 0;
  int n_fail   = 0;
  int consumed = 0;

  alu_req_t     mq[$];
  logic         m_valid;
  logic [W-1:0] m_res;
  logic         m_carry;
  logic         m_ovf;

  alu_issue_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_calc(input alu_req_t r, output logic [W-1:0] res,
                                   output logic c, output logic o);
    logic [W:0]   full;
    logic [W-1:0] bp;
    if (!r.sub) begin
      full = {1'b0, r.a} + {1'b0, r.b};
      res  = full[W-1:0];
      c    = full[W];
      bp   = r.b;
    end else begin
      res = r.a - r.b;
      c   = (r.a < r.b);
      bp  = -r.b;
    end
    o = (r.a[W-1] == bp[W-1]) && (res[W-1] != r.a[W-1]);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_res   = '0;
    m_carry = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 64'(rsp_valid), 64'(m_valid));
    check({tag, ".count"}, 64'(count), 64'(mq.size()));
    check({tag, ".ready"}, 64'(req_ready), 64'(!flush && mq.size() != D));
    check({tag, ".res"},   64'(rsp_res), 64'(m_res));
    check({tag, ".carry"}, 64'(rsp_carry), 64'(m_carry));
    check({tag, ".ovf"},   64'(rsp_ovf), 64'(m_ovf));
  endtask

  // One clock: decide model actions from pre-edge state, advance, compare.
  task automatic tick(input string tag);
    bit       do_push;
    bit       do_pop;
    alu_req_t r;
    alu_req_t nr;
    do_push = req_valid && !flush && (mq.size() < D);
    do_pop  = (mq.size() != 0) && (!m_valid || rsp_ready) && !flush;
    nr = '{a: req_a, b: req_b, sub: req_sub};
    if (rsp_valid && rsp_ready) consumed++;
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete();
      m_valid = 1'b0;
    end else begin
      if (do_pop) begin
        r = mq.pop_front();
        ref_calc(r, m_res, m_carry, m_ovf);
        m_valid = 1'b1;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      if (do_push) mq.push_back(nr);
    end
    check_outputs(tag);
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0000_0000;
      1: v = 32'h0000_0001;
      2: v = 32'h7FFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic set_req(input bit v, input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_sub   = s;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                       input logic [W-1:0] er, input bit ec, input bit eo);
    set_req(1'b1, a, b, s);
    tick("issue_acc");
    set_req(1'b0, '0, '0, 1'b0);
    tick("issue_rsp");
    check("issue.valid", 64'(rsp_valid), 64'd1);
    check("issue.res",   64'(rsp_res), 64'(er));
    check("issue.carry", 64'(rsp_carry), 64'(ec));
    check("issue.ovf",   64'(rsp_ovf), 64'(eo));
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    set_req(1'b0, '0, '0, 1'b0);
    model_reset();
    #12;
    check("rst.valid", 64'(rsp_valid), 64'd0);
    check("rst.count", 64'(count), 64'd0);
    check("rst.res",   64'(rsp_res), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst.ready", 64'(req_ready), 64'd1);

    // Single add with two-edge latency
    set_req(1'b1, 32'd5, 32'd7, 1'b0);
    tick("add_k");
    check("add_k.valid", 64'(rsp_valid), 64'd0);
    set_req(1'b0, '0, '0, 1'b0);
    tick("add_k1");
    check("add.valid", 64'(rsp_valid), 64'd1);
    check("add.res",   64'(rsp_res), 64'd12);
    check("add.carry", 64'(rsp_carry), 64'd0);
    check("add.ovf",   64'(rsp_ovf), 64'd0);

    // Flag corners
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    issue(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    issue(32'd3,         32'd5, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);

    // Backpressure: 1 held + 4 queued, then drain in order
    tick("pre_bp");
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      tick("bp_fill");
    end
    set_req(1'b0, '0, '0, 1'b0);
    #1;
    check("bp.count", 64'(count), 64'd4);
    check("bp.ready", 64'(req_ready), 64'd0);
    consumed  = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick("bp_drain");
    check("bp.consumed", 64'(consumed), 64'd5);

    // Simultaneous push/pop at count=2
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      tick("pp_fill");
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_req(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      tick("pp_run");
      check("pp.count", 64'(count), 64'd2);
    end
    set_req(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) tick("pp_drain");

    // Flush with count=3 and a held response
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      tick("fl_fill");
    end
    check("fl.pre_count", 64'(count), 64'd3);
    flush = 1'b1;
    set_req(1'b1, 32'd9, 32'd9, 1'b0);
    #1;
    check("fl.ready", 64'(req_ready), 64'd0);
    tick("fl_edge");
    check("fl.count", 64'(count), 64'd0);
    check("fl.valid", 64'(rsp_valid), 64'd0);
    flush = 1'b0;
    set_req(1'b0, '0, '0, 1'b0);
    rsp_ready = 1'b1;
    tick("fl_after");

    // Asynchronous reset mid-stream
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      tick("mr_fill");
    end
    set_req(1'b0, '0, '0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mr.valid", 64'(rsp_valid), 64'd0);
    check("mr.count", 64'(count), 64'd0);
    check("mr.res",   64'(rsp_res), 64'd0);
    check("mr.carry", 64'(rsp_carry), 64'd0);
    check("mr.ovf",   64'(rsp_ovf), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("mr.ready", 64'(req_ready), 64'd1);
    rsp_ready = 1'b1;
    tick("mr_after");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      set_req(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      rsp_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
